// File: rtl/clock_div_monitor.sv
// Checks one divided clock: measures its period and high time in clk_in cycles, compares them against expected values, tracks lock and flags a stall.
// Latency: period/high_cnt/meas_valid update on the same clk_in edge that samples the closing rise of sig_in (registered outputs, no extra stages).
// Backpressure: none; the block observes only and never stalls. Results are pulse-qualified by meas_valid, which is at most one cycle in two.
module clock_div_monitor #(
    parameter int CNT_W      = 8,
    parameter int LOCK_COUNT = 4
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic [CNT_W-1:0] exp_period,
    input  logic [CNT_W-1:0] exp_high,
    input  logic             clear,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_cnt,
    output logic             meas_valid,
    output logic             mismatch,
    output logic             mismatch_sticky,
    output logic             locked,
    output logic             timeout
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MEAS  = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [4:0]       LOCK_TGT = 5'(LOCK_COUNT);

    logic [1:0]       state_q, state_d;
    logic             sig_d_q, sig_d_d;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [3:0]       match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             meas_valid_q, meas_valid_d;
    logic             mismatch_q, mismatch_d;
    logic             sticky_q, sticky_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;

    logic             rise;
    logic             per_sat;
    logic             hi_sat;
    logic             meas_bad;
    logic [4:0]       match_inc;

    assign rise      = sig_in & ~sig_d_q;
    assign per_sat   = (per_cnt_q == CNT_MAX);
    assign hi_sat    = (hi_cnt_q == CNT_MAX);
    assign meas_bad  = (per_cnt_q != exp_period) | (hi_cnt_q != exp_high);
    assign match_inc = {1'b0, match_cnt_q} + 5'd1;

    // Next-state: edge detect, saturating counters, measurement FSM, lock tracking, then soft clear on top.
    always_comb begin
        state_d      = state_q;
        sig_d_d      = sig_in;
        per_cnt_d    = per_cnt_q;
        hi_cnt_d     = hi_cnt_q;
        match_cnt_d  = match_cnt_q;
        period_d     = period_q;
        high_d       = high_q;
        meas_valid_d = 1'b0;
        mismatch_d   = mismatch_q;
        sticky_d     = sticky_q;
        locked_d     = locked_q;
        timeout_d    = timeout_q;

        // The rising edge itself is the first cycle of the new period and of its high phase.
        if (rise) begin
            per_cnt_d = CNT_ONE;
            hi_cnt_d  = CNT_ONE;
        end else begin
            per_cnt_d = per_sat ? per_cnt_q : per_cnt_q + CNT_ONE;
            hi_cnt_d  = (hi_sat || !sig_in) ? hi_cnt_q : hi_cnt_q + CNT_ONE;
        end

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_MEAS;
                end else if (per_sat) begin
                    state_d     = ST_STALL;
                    timeout_d   = 1'b1;
                    locked_d    = 1'b0;
                    match_cnt_d = 4'd0;
                end
            end
            ST_MEAS: begin
                // A rise takes priority over saturation, so a full-scale period is still measured.
                if (rise) begin
                    period_d     = per_cnt_q;
                    high_d       = hi_cnt_q;
                    meas_valid_d = 1'b1;
                    mismatch_d   = meas_bad;
                    if (meas_bad) begin
                        match_cnt_d = 4'd0;
                        locked_d    = 1'b0;
                        sticky_d    = 1'b1;
                    end else begin
                        match_cnt_d = (match_inc >= LOCK_TGT) ? LOCK_TGT[3:0] : match_inc[3:0];
                        locked_d    = (match_inc >= LOCK_TGT);
                    end
                end else if (per_sat) begin
                    state_d     = ST_STALL;
                    timeout_d   = 1'b1;
                    locked_d    = 1'b0;
                    match_cnt_d = 4'd0;
                end
            end
            ST_STALL: begin
                // The period straddling the stall is meaningless, so only restart measurement here.
                if (rise) begin
                    state_d   = ST_MEAS;
                    timeout_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Soft clear wins over any coincident rise; the last results stay readable.
        if (clear) begin
            state_d      = ST_IDLE;
            per_cnt_d    = '0;
            hi_cnt_d     = '0;
            match_cnt_d  = 4'd0;
            period_d     = period_q;
            high_d       = high_q;
            meas_valid_d = 1'b0;
            mismatch_d   = 1'b0;
            sticky_d     = 1'b0;
            locked_d     = 1'b0;
            timeout_d    = 1'b0;
        end
    end

    // State registers; sig_d resets high so a clock already high at release is not seen as a rise.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sig_d_q      <= 1'b1;
            per_cnt_q    <= '0;
            hi_cnt_q     <= '0;
            match_cnt_q  <= 4'd0;
            period_q     <= '0;
            high_q       <= '0;
            meas_valid_q <= 1'b0;
            mismatch_q   <= 1'b0;
            sticky_q     <= 1'b0;
            locked_q     <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sig_d_q      <= sig_d_d;
            per_cnt_q    <= per_cnt_d;
            hi_cnt_q     <= hi_cnt_d;
            match_cnt_q  <= match_cnt_d;
            period_q     <= period_d;
            high_q       <= high_d;
            meas_valid_q <= meas_valid_d;
            mismatch_q   <= mismatch_d;
            sticky_q     <= sticky_d;
            locked_q     <= locked_d;
            timeout_q    <= timeout_d;
        end
    end

    assign period          = period_q;
    assign high_cnt        = high_q;
    assign meas_valid      = meas_valid_q;
    assign mismatch        = mismatch_q;
    assign mismatch_sticky = sticky_q;
    assign locked          = locked_q;
    assign timeout         = timeout_q;

endmodule

// File: tb/tb_clock_div_monitor.sv
// Directed bench for clock_div_monitor (CNT_W=8, LOCK_COUNT=4) with hand-computed expectations.
// Latency: outputs are sampled 1 time unit after each rising clk_in edge.
// Backpressure: not applicable; stimulus is a fixed linear sequence.
module tb_clock_div_monitor;

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic       sig_in;
    logic [7:0] exp_period;
    logic [7:0] exp_high;
    logic       clear;
    logic [7:0] period;
    logic [7:0] high_cnt;
    logic       meas_valid;
    logic       mismatch;
    logic       mismatch_sticky;
    logic       locked;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    clock_div_monitor #(.CNT_W(8), .LOCK_COUNT(4)) dut (
        .clk_in          (clk_in),
        .rst_n           (rst_n),
        .sig_in          (sig_in),
        .exp_period      (exp_period),
        .exp_high        (exp_high),
        .clear           (clear),
        .period          (period),
        .high_cnt        (high_cnt),
        .meas_valid      (meas_valid),
        .mismatch        (mismatch),
        .mismatch_sticky (mismatch_sticky),
        .locked          (locked),
        .timeout         (timeout)
    );

    always #5 clk_in = ~clk_in;

    // Drive sig_in for one clk_in edge, then settle just after the edge.
    task automatic step(input logic v);
        sig_in = v;
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_period"}, 32'(period), 0);
        chk({tag, "_high"}, 32'(high_cnt), 0);
        chk({tag, "_mv"}, 32'(meas_valid), 0);
        chk({tag, "_mm"}, 32'(mismatch), 0);
        chk({tag, "_sticky"}, 32'(mismatch_sticky), 0);
        chk({tag, "_locked"}, 32'(locked), 0);
        chk({tag, "_timeout"}, 32'(timeout), 0);
    endtask

    initial begin
        rst_n = 1'b0; sig_in = 1'b0; clear = 1'b0;
        exp_period = 8'd2; exp_high = 8'd1;
        drive(1'b0, 2);
        chk_all_zero("reset");

        // Divide-by-2: lock with the 4th measurement.
        rst_n = 1'b1;
        step(1'b0);
        step(1'b1);
        chk("div2_first_rise_mv", 32'(meas_valid), 0);
        for (int i = 1; i <= 4; i++) begin
            step(1'b0);
            chk("div2_low_mv", 32'(meas_valid), 0);
            step(1'b1);
            chk("div2_mv", 32'(meas_valid), 1);
            chk("div2_period", 32'(period), 2);
            chk("div2_high", 32'(high_cnt), 1);
            chk("div2_locked", 32'(locked), (i == 4) ? 1 : 0);
        end
        chk("div2_mismatch", 32'(mismatch), 0);

        // Divide-by-26, 13 high / 13 low.
        step(1'b0);
        step(1'b1);
        exp_period = 8'd26; exp_high = 8'd13;
        drive(1'b1, 12); drive(1'b0, 13); step(1'b1);
        chk("div26_mv", 32'(meas_valid), 1);
        chk("div26_period", 32'(period), 26);
        chk("div26_high", 32'(high_cnt), 13);
        chk("div26_mismatch", 32'(mismatch), 0);
        chk("div26_locked", 32'(locked), 1);
        exp_high = 8'd12;
        drive(1'b1, 12); drive(1'b0, 13); step(1'b1);
        chk("div26_bad_mismatch", 32'(mismatch), 1);
        chk("div26_bad_sticky", 32'(mismatch_sticky), 1);
        chk("div26_bad_locked", 32'(locked), 0);
        exp_high = 8'd13;
        drive(1'b1, 12); drive(1'b0, 13); step(1'b1);
        chk("div26_restore_mismatch", 32'(mismatch), 0);
        chk("div26_restore_sticky", 32'(mismatch_sticky), 1);

        // Stall: rise at edge 0, low afterwards; timeout after edge 255.
        drive(1'b0, 254);
        chk("stall_pre_timeout", 32'(timeout), 0);
        step(1'b0);
        chk("stall_timeout", 32'(timeout), 1);
        chk("stall_locked", 32'(locked), 0);
        step(1'b0);
        chk("stall_timeout_level", 32'(timeout), 1);
        step(1'b1);
        chk("stall_exit_mv", 32'(meas_valid), 0);
        chk("stall_exit_timeout", 32'(timeout), 0);
        step(1'b0); step(1'b1);
        chk("stall_resume_mv", 32'(meas_valid), 1);
        chk("stall_resume_period", 32'(period), 2);
        drive(1'b0, 254);
        chk("p255_pre_timeout", 32'(timeout), 0);
        step(1'b1);
        chk("p255_mv", 32'(meas_valid), 1);
        chk("p255_period", 32'(period), 255);
        chk("p255_high", 32'(high_cnt), 1);
        chk("p255_timeout", 32'(timeout), 0);

        // sig_in high across reset release is not a rise.
        rst_n = 1'b0;
        drive(1'b1, 2);
        chk_all_zero("rst_high");
        rst_n = 1'b1;
        exp_period = 8'd2; exp_high = 8'd1;
        drive(1'b1, 3);
        chk("rst_high_hold_mv", 32'(meas_valid), 0);
        step(1'b0); step(1'b1);
        chk("rst_high_first_rise_mv", 32'(meas_valid), 0);
        step(1'b0); step(1'b1);
        chk("rst_high_meas_mv", 32'(meas_valid), 1);
        chk("rst_high_meas_period", 32'(period), 2);
        chk("rst_high_meas_mismatch", 32'(mismatch), 0);

        // Clear on a rise while locked with sticky set.
        exp_high = 8'd0;
        step(1'b0); step(1'b1);
        chk("clr_setup_sticky", 32'(mismatch_sticky), 1);
        exp_high = 8'd1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0); step(1'b1);
        end
        chk("clr_setup_locked", 32'(locked), 1);
        step(1'b0);
        clear = 1'b1;
        step(1'b1);
        clear = 1'b0;
        chk("clr_mv", 32'(meas_valid), 0);
        chk("clr_locked", 32'(locked), 0);
        chk("clr_sticky", 32'(mismatch_sticky), 0);
        chk("clr_period_hold", 32'(period), 2);
        chk("clr_high_hold", 32'(high_cnt), 1);
        step(1'b0); step(1'b1);
        chk("clr_first_rise_mv", 32'(meas_valid), 0);
        step(1'b0); step(1'b1);
        chk("clr_second_rise_mv", 32'(meas_valid), 1);

        // Reset mid-period while locked, then re-lock after 5 rises.
        for (int i = 0; i < 3; i++) begin
            step(1'b0); step(1'b1);
        end
        chk("rstmid_setup_locked", 32'(locked), 1);
        step(1'b0);
        rst_n = 1'b0;
        step(1'b0);
        chk_all_zero("rstmid");
        rst_n = 1'b1;
        step(1'b0);
        for (int r = 1; r <= 5; r++) begin
            step(1'b1);
            chk("relock_locked", 32'(locked), (r == 5) ? 1 : 0);
            step(1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
